// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised input, PRESCALE-times oversampling, 3-sample mid-bit
// majority vote, 8N1 or 8-with-parity frames, registered strobe and error pulses.
//   state  | meaning
//   IDLE   | line idle, waiting for rx_s low
//   START  | start bit, glitch rejected on a 1 vote
//   DATA   | 8 data bits, LSB first
//   PARITY | parity bit check (only when PAR_EN latched 1)
//   STOP   | stop bit, decide right after the third sample
module uart_rx #(
    parameter int PRESCALE    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic [7:0] P_DATA,
    output logic       Data_Valid,
    output logic       PAR_ERR,
    output logic       STP_ERR,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int EW = $clog2(PRESCALE);
    localparam logic [EW-1:0] S_LO   = EW'(PRESCALE / 2 - 1);
    localparam logic [EW-1:0] S_MID  = EW'(PRESCALE / 2);
    localparam logic [EW-1:0] S_HI   = EW'(PRESCALE / 2 + 1);
    localparam logic [EW-1:0] E_LAST = EW'(PRESCALE - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [EW-1:0]          edge_cnt_q, edge_cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [1:0]             smp_q, smp_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_en_q, par_en_d;
    logic                   par_typ_q, par_typ_d;
    logic                   par_bad_q, par_bad_d;
    logic [7:0]             p_data_q, p_data_d;
    logic                   valid_q, valid_d;
    logic                   par_err_q, par_err_d;
    logic                   stp_err_q, stp_err_d;
    logic                   busy_q, busy_d;

    logic rx_s, vote_now, bit_end, vote, par_exp;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign vote_now = (edge_cnt_q == S_HI);
    assign bit_end  = (edge_cnt_q == E_LAST);
    assign vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    assign par_exp  = par_typ_q ? ~(^shift_q) : ^shift_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            sync_q     <= '1;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            smp_q      <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            p_data_q   <= '0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q[0] <= RX_IN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            smp_q      <= smp_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_bad_q  <= par_bad_d;
            p_data_q   <= p_data_d;
            valid_q    <= valid_d;
            par_err_q  <= par_err_d;
            stp_err_q  <= stp_err_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (!rx_s) state_d = START;
            START: begin
                if (vote_now && vote) state_d = IDLE;
                else if (bit_end)     state_d = DATA;
            end
            DATA:   if (bit_end && bit_cnt_q == 4'd8) state_d = par_en_q ? PARITY : STOP;
            PARITY: if (bit_end) state_d = STOP;
            STOP:   if (vote_now) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        smp_d      = smp_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_bad_d  = par_bad_q;
        p_data_d   = p_data_q;
        valid_d    = 1'b0;
        par_err_d  = 1'b0;
        stp_err_d  = 1'b0;
        busy_d     = busy_q;
        if (state_q == IDLE) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
            // The detecting cycle already counts as edge 0 of the start bit.
            if (!rx_s) begin
                edge_cnt_d = EW'(1);
                busy_d     = 1'b1;
                par_en_d   = PAR_EN;
                par_typ_d  = PAR_TYP;
                par_bad_d  = 1'b0;
            end
        end else begin
            edge_cnt_d = bit_end ? '0 : edge_cnt_q + 1'b1;
            if (bit_end) bit_cnt_d = bit_cnt_q + 4'd1;
            if (edge_cnt_q == S_LO)  smp_d[0] = rx_s;
            if (edge_cnt_q == S_MID) smp_d[1] = rx_s;
            if (vote_now) begin
                case (state_q)
                    START: begin
                        if (vote) busy_d = 1'b0;
                    end
                    DATA:   shift_d = {vote, shift_q[7:1]};
                    PARITY: if (vote != par_exp) par_bad_d = 1'b1;
                    STOP: begin
                        busy_d = 1'b0;
                        if (vote && !par_bad_q) begin
                            p_data_d = shift_q;
                            valid_d  = 1'b1;
                        end
                        stp_err_d = ~vote;
                        par_err_d = par_bad_q;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign P_DATA     = p_data_q;
    assign Data_Valid = valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at PRESCALE=8, SYNC_STAGES=2; a passive monitor counts pulses
// and their cycle numbers, the linear sequence below checks them against hand values.
module tb_uart_rx;
   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       RX_IN = 1'b1;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [7:0] P_DATA;
   logic       Data_Valid, PAR_ERR, STP_ERR, busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int start_cyc = 0;
   int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, width_viol = 0;
   int dv_cyc = -1, pe_cyc = -1, se_cyc = -1;
   logic [7:0] dv_last = 8'h00, dv_last2 = 8'h00;
   logic busy_at_pulse = 1'b0;
   logic dv_p = 1'b0, pe_p = 1'b0, se_p = 1'b0;
   int dv0, pe0, se0;

   uart_rx #(.PRESCALE(8), .SYNC_STAGES(2)) dut (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
      .P_DATA(P_DATA), .Data_Valid(Data_Valid), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR),
      .busy(busy)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (Data_Valid) begin
         dv_cnt++; dv_cyc = cyc; dv_last2 = dv_last; dv_last = P_DATA; busy_at_pulse = busy;
      end
      if (PAR_ERR) begin pe_cnt++; pe_cyc = cyc; end
      if (STP_ERR) begin se_cnt++; se_cyc = cyc; end
      if ((Data_Valid && dv_p) || (PAR_ERR && pe_p) || (STP_ERR && se_p)) width_viol++;
      dv_p = Data_Valid; pe_p = PAR_ERR; se_p = STP_ERR;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Frame bits are held 8 clocks each; the stop bit may be shortened for back-to-back tests.
   task automatic send_frame(input logic [7:0] d, input bit with_par, input logic par_bit,
                             input logic stop_bit, input int stop_len, input int glitch_bit);
      logic [10:0] fr;
      int n, len;
      fr = '1;
      fr[0] = 1'b0;
      fr[8:1] = d;
      if (with_par) begin fr[9] = par_bit; fr[10] = stop_bit; n = 11; end
      else begin fr[9] = stop_bit; n = 10; end
      start_cyc = cyc;
      for (int b = 0; b < n; b++) begin
         len = (b == n - 1) ? stop_len : 8;
         for (int k = 0; k < len; k++) begin
            RX_IN = (b == glitch_bit && k == 4) ? ~fr[b] : fr[b];
            @(negedge CLK);
         end
      end
      RX_IN = 1'b1;
   endtask

   task automatic snap();
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
   endtask

   initial begin
      repeat (3) @(negedge CLK);
      chk("rst_pdata", P_DATA, 8'h00);
      chk("rst_dv", Data_Valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_errs", {PAR_ERR, STP_ERR}, 2'b00);
      RST = 1'b0;
      repeat (4) @(negedge CLK);

      PAR_EN = 1'b1; PAR_TYP = 1'b0; snap();
      fork
         send_frame(8'hDB, 1'b1, 1'b0, 1'b1, 8, -1);
         begin repeat (20) @(negedge CLK); chk("busy_mid", busy, 1'b1); end
      join
      repeat (6) @(negedge CLK);
      chk("db_dv_cnt", dv_cnt - dv0, 1);
      chk("db_data", P_DATA, 8'hDB);
      chk("db_errs", (pe_cnt - pe0) + (se_cnt - se0), 0);
      chk("db_latency", dv_cyc, start_cyc + 88);
      chk("db_busy_at_dv", busy_at_pulse, 1'b0);

      PAR_TYP = 1'b1; snap();
      send_frame(8'hAA, 1'b1, 1'b1, 1'b1, 8, -1);
      repeat (6) @(negedge CLK);
      chk("aa_dv_cnt", dv_cnt - dv0, 1);
      chk("aa_data", P_DATA, 8'hAA);
      snap();
      send_frame(8'hAA, 1'b1, 1'b0, 1'b1, 8, -1);
      repeat (6) @(negedge CLK);
      chk("aa_pe_cnt", pe_cnt - pe0, 1);
      chk("aa_pe_latency", pe_cyc, start_cyc + 88);
      chk("aa_pe_no_dv", dv_cnt - dv0, 0);
      chk("aa_pe_no_se", se_cnt - se0, 0);
      chk("aa_pe_hold", P_DATA, 8'hAA);

      PAR_EN = 1'b0; snap();
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 8, -1);
      repeat (16) @(negedge CLK);
      chk("3c_se_cnt", se_cnt - se0, 1);
      chk("3c_se_latency", se_cyc, start_cyc + 80);
      chk("3c_se_no_pe", pe_cnt - pe0, 0);
      chk("3c_se_no_dv", dv_cnt - dv0, 0);
      chk("3c_se_hold", P_DATA, 8'hAA);
      snap();
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 8, -1);
      repeat (6) @(negedge CLK);
      chk("3c_dv_cnt", dv_cnt - dv0, 1);
      chk("3c_data", P_DATA, 8'h3C);

      snap();
      RX_IN = 1'b0;
      repeat (2) @(negedge CLK);
      RX_IN = 1'b1;
      repeat (2) @(negedge CLK);
      chk("glitch_busy_hi", busy, 1'b1);
      repeat (10) @(negedge CLK);
      chk("glitch_busy_lo", busy, 1'b0);
      chk("glitch_no_pulse", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);

      PAR_EN = 1'b1; PAR_TYP = 1'b0; snap();
      send_frame(8'h55, 1'b1, 1'b0, 1'b1, 8, 3);
      repeat (6) @(negedge CLK);
      chk("55_dv_cnt", dv_cnt - dv0, 1);
      chk("55_data", P_DATA, 8'h55);

      PAR_EN = 1'b0; snap();
      send_frame(8'h01, 1'b0, 1'b0, 1'b1, 7, -1);
      send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 8, -1);
      repeat (6) @(negedge CLK);
      chk("b2b_dv_cnt", dv_cnt - dv0, 2);
      chk("b2b_first", dv_last2, 8'h01);
      chk("b2b_second", dv_last, 8'hFE);
      chk("b2b_latency", dv_cyc, start_cyc + 80);

      PAR_EN = 1'b1; PAR_TYP = 1'b0; snap();
      RX_IN = 1'b0; repeat (8) @(negedge CLK);
      RX_IN = 1'b1; repeat (8) @(negedge CLK);
      RX_IN = 1'b0; repeat (4) @(negedge CLK);
      RST = 1'b1; RX_IN = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("mid_rst_outs", {P_DATA, Data_Valid, PAR_ERR, STP_ERR, busy}, 12'h000);
      repeat (100) @(negedge CLK);
      chk("mid_rst_no_pulse", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
      send_frame(8'h81, 1'b1, 1'b0, 1'b1, 8, -1);
      repeat (6) @(negedge CLK);
      chk("81_dv_cnt", dv_cnt - dv0, 1);
      chk("81_data", P_DATA, 8'h81);
      chk("pulse_width", width_viol, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
